// File: rtl/simd_pipe_pkg.sv
// simd_pipe_pkg: shared types, forward codes and unit timing for the even-pipe issue stage
package simd_pipe_pkg;
  localparam int DEPTH = 7;
  localparam int AW = 7;
  localparam int CNTW = 16;
  localparam int SW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {U_BYTE = 2'b00, U_FX1 = 2'b01, U_FX2 = 2'b10, U_FP = 2'b11} unit_e;
  localparam logic [3:0] FWD_RF = 4'b0000;
  localparam logic [3:0] FWD_FX1 = 4'b0001;
  localparam logic [3:0] FWD_FX2 = 4'b0111;
  localparam logic [3:0] FWD_BYTE = 4'b1000;
  localparam logic [3:0] FWD_FP = 4'b1001;
  localparam logic [SW-1:0] FIRST_BYTE = SW'(4);
  localparam logic [SW-1:0] FIRST_FX1 = SW'(2);
  localparam logic [SW-1:0] FIRST_FX2 = SW'(4);
  localparam logic [SW-1:0] FIRST_FP = SW'(6);
  localparam logic [SW-1:0] LAST_FP = SW'(6);
  typedef struct packed {
    logic we;
    logic [AW-1:0] rt;
    unit_e unit;
  } tag_t;
  typedef struct packed {
    logic valid;
    logic [7:0] cse;
    logic [AW-1:0] rt;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rc;
    logic [2:0] used;
  } ir_t;
  function automatic logic [SW-1:0] first_slot(unit_e u);
    return u == U_BYTE ? FIRST_BYTE : u == U_FX1 ? FIRST_FX1 : u == U_FX2 ? FIRST_FX2 : FIRST_FP;
  endfunction
  function automatic logic [3:0] unit_code(unit_e u);
    return u == U_BYTE ? FWD_BYTE : u == U_FX1 ? FWD_FX1 : u == U_FX2 ? FWD_FX2 : FWD_FP;
  endfunction
endpackage

// File: rtl/even_scoreboard.sv
// even_scoreboard: pipe tag shift register with a youngest-match forward lookup for one source
module even_scoreboard import simd_pipe_pkg::*; (
  input  logic          clk,
  input  logic          reset,
  input  tag_t          push,
  input  logic [AW-1:0] src,
  input  logic          src_used,
  output logic          stall,
  output logic [3:0]    code
);
  tag_t [DEPTH:1] slot_q, slot_d;
  logic hit;
  logic [SW-1:0] hs;
  unit_e hu;
  always_comb slot_d = {slot_q[DEPTH-1:1], push};
  always_ff @(posedge clk) slot_q <= reset ? '0 : slot_d;
  always_comb begin
    hit = 1'b0;
    hs = '0;
    hu = U_BYTE;
    for (int s = DEPTH; s >= 1; s--) begin
      if (src_used && slot_q[s].we && slot_q[s].rt == src) begin
        hit = 1'b1;
        hs = SW'(s);
        hu = slot_q[s].unit;
      end
    end
    stall = hit && (hs < first_slot(hu) || (hu == U_FP && hs > LAST_FP));
    code = !hit || stall ? FWD_RF : hs == first_slot(hu) ? unit_code(hu) : {1'b0, hs - SW'(1)};
  end
endmodule

// File: rtl/even_issue_stage.sv
// even_issue_stage: single-entry issue register with RAW hazard stall and forward-select generation
module even_issue_stage import simd_pipe_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_cse,
  input  logic [AW-1:0]   in_rt,
  input  logic [AW-1:0]   in_ra,
  input  logic [AW-1:0]   in_rb,
  input  logic [AW-1:0]   in_rc,
  input  logic [2:0]      in_use,
  output logic [7:0]      cse_out,
  output logic [AW-1:0]   addr_out,
  output logic [3:0]      fwd_a,
  output logic [3:0]      fwd_b,
  output logic [3:0]      fwd_c,
  output logic            issue,
  output logic [CNTW-1:0] stall_cnt
);
  ir_t ir_q, ir_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [2:0] stall_v;
  logic [3:0] code [3];
  logic [AW-1:0] src [3];
  logic hazard;
  tag_t push;
  always_comb begin
    src = '{ir_q.ra, ir_q.rb, ir_q.rc};
    hazard = ir_q.valid && ir_q.cse[0] && |stall_v;
    issue = ir_q.valid && !hazard;
    in_ready = !ir_q.valid || issue;
    push = '{we: issue && ir_q.cse[0], rt: ir_q.rt, unit: unit_e'(ir_q.cse[2:1])};
    ir_d = in_valid && in_ready ? ir_t'{1'b1, in_cse, in_rt, in_ra, in_rb, in_rc, in_use} : issue ? '0 : ir_q;
    stall_cnt_d = hazard && !(&stall_cnt_q) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
    cse_out = issue ? ir_q.cse : '0;
    addr_out = issue ? ir_q.rt : '0;
    fwd_a = issue ? code[0] : '0;
    fwd_b = issue ? code[1] : '0;
    fwd_c = issue ? code[2] : '0;
    stall_cnt = stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    ir_q <= reset ? '0 : ir_d;
    stall_cnt_q <= reset ? '0 : stall_cnt_d;
  end
  for (genvar i = 0; i < 3; i++) begin : g_sb
    even_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .src      (src[i]),
      .src_used (ir_q.used[2-i]),
      .stall    (stall_v[i]),
      .code     (code[i])
    );
  end
endmodule

// File: tb/tb_even_issue_stage.sv
// tb_even_issue_stage: randomized scoreboard bench for the even-pipe issue stage
module tb_even_issue_stage;
  localparam int D = 7;
  localparam int TAB [4][7] = '{
    '{-1, -1, -1,  8,  4,  5,  6},
    '{-1,  1,  2,  3,  4,  5,  6},
    '{-1, -1, -1,  7,  4,  5,  6},
    '{-1, -1, -1, -1, -1,  9, -1}
  };
  typedef struct { logic [7:0] cse; logic [6:0] rt, ra, rb, rc; logic [2:0] used; } ins_t;
  typedef struct { int c; logic [6:0] rt; logic [1:0] u; } wr_t;
  typedef struct { int c; logic [7:0] cse; logic [6:0] rt; logic [3:0] fa, fb, fc; } exp_t;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [7:0] in_cse = 0;
  logic [6:0] in_rt = 0, in_ra = 0, in_rb = 0, in_rc = 0;
  logic [2:0] in_use = 0;
  logic in_ready, issue;
  logic [7:0] cse_out;
  logic [6:0] addr_out;
  logic [3:0] fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_cnt;
  int cyc = 0, n_cmp = 0, n_bad = 0, n_issue = 0, last_iss_cyc = -1;
  bit running = 0;
  ins_t m_ir;
  bit m_valid = 0, m_iss = 0, m_rdy = 1;
  int m_cnt = 0;
  wr_t hist[$];
  exp_t expq[$];
  logic [3:0] last_fa = 0, last_fb = 0, last_fc = 0;

  even_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_cse(in_cse),
    .in_rt(in_rt), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_use(in_use),
    .cse_out(cse_out), .addr_out(addr_out), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .issue(issue), .stall_cnt(stall_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lookup(logic [6:0] r, logic used);
    if (!used) return 0;
    for (int j = 0; j < hist.size(); j++)
      if (hist[j].rt == r && cyc - hist[j].c <= D) return TAB[hist[j].u][cyc - hist[j].c - 1];
    return 0;
  endfunction

  task automatic model_step();
    int k[3];
    bit haz;
    cyc++;
    if (reset) begin
      m_valid = 0;
      hist.delete();
      m_cnt = 0;
    end else begin
      if (m_iss && m_ir.cse[0]) hist.push_front('{cyc - 1, m_ir.rt, m_ir.cse[2:1]});
      if (m_valid && !m_iss && m_cnt < 65535) m_cnt++;
      if (in_valid && m_rdy) begin
        m_ir = '{in_cse, in_rt, in_ra, in_rb, in_rc, in_use};
        m_valid = 1;
      end else if (m_iss) m_valid = 0;
    end
    while (hist.size() > 0 && cyc - hist[$].c > D) void'(hist.pop_back());
    m_iss = 0;
    if (m_valid) begin
      k[0] = lookup(m_ir.ra, m_ir.used[2]);
      k[1] = lookup(m_ir.rb, m_ir.used[1]);
      k[2] = lookup(m_ir.rc, m_ir.used[0]);
      haz = m_ir.cse[0] && (k[0] < 0 || k[1] < 0 || k[2] < 0);
      m_iss = !haz;
      if (m_iss)
        expq.push_back('{cyc, m_ir.cse, m_ir.rt, 4'(k[0] < 0 ? 0 : k[0]),
                         4'(k[1] < 0 ? 0 : k[1]), 4'(k[2] < 0 ? 0 : k[2])});
    end
    m_rdy = !m_valid || m_iss;
  endtask

  task automatic monitor_step();
    exp_t e;
    chk("in_ready", in_ready, m_rdy);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (issue) begin
      n_issue++;
      last_iss_cyc = cyc;
      last_fa = fwd_a;
      last_fb = fwd_b;
      last_fc = fwd_c;
      chk("issue_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("issue_cycle", cyc, e.c);
        chk("cse_out", cse_out, e.cse);
        chk("addr_out", addr_out, e.rt);
        chk("fwd_a", fwd_a, e.fa);
        chk("fwd_b", fwd_b, e.fb);
        chk("fwd_c", fwd_c, e.fc);
      end
    end else begin
      chk("idle_outputs", {cse_out, addr_out, fwd_a, fwd_b, fwd_c}, 0);
      if (expq.size() > 0 && expq[0].c <= cyc) begin
        chk("missed_issue", issue, 1);
        void'(expq.pop_front());
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (running) monitor_step();
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic send(input logic [7:0] c, input int rt, input int ra, input int rb, input int rc,
                      input logic [2:0] u);
    int t = 0;
    in_valid = 1;
    in_cse = c;
    in_rt = 7'(rt);
    in_ra = 7'(ra);
    in_rb = 7'(rb);
    in_rc = 7'(rc);
    in_use = u;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    logic [15:0] s0;
    int j, n0;
    logic [7:0] c;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    running = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_issue", issue, 0);
    chk("rst_cse_out", cse_out, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    send(8'h03, 5, 0, 0, 0, 3'b000);
    send(8'h03, 6, 5, 0, 0, 3'b100);
    idle(10);
    chk("fx1_fwd_a", last_fa, 4'b0001);
    chk("fx1_stall_cnt", stall_cnt, 1);
    s0 = stall_cnt;
    send(8'h01, 10, 0, 0, 0, 3'b000);
    send(8'h03, 11, 0, 10, 0, 3'b010);
    idle(10);
    chk("byte_fwd_b", last_fb, 4'b1000);
    chk("byte_stalls", stall_cnt - s0, 3);
    s0 = stall_cnt;
    send(8'h05, 10, 0, 0, 0, 3'b000);
    send(8'h03, 11, 0, 10, 0, 3'b010);
    idle(10);
    chk("fx2_fwd_b", last_fb, 4'b0111);
    chk("fx2_stalls", stall_cnt - s0, 3);
    s0 = stall_cnt;
    send(8'h07, 3, 0, 0, 0, 3'b000);
    send(8'h03, 12, 0, 0, 3, 3'b001);
    idle(10);
    chk("fp_fwd_c", last_fc, 4'b1001);
    chk("fp_stalls", stall_cnt - s0, 5);
    s0 = stall_cnt;
    send(8'h07, 3, 0, 0, 0, 3'b000);
    idle(6);
    send(8'h03, 13, 0, 0, 3, 3'b001);
    idle(10);
    chk("fp_s7_fwd_c", last_fc, 4'b0000);
    chk("fp_s7_stalls", stall_cnt - s0, 1);
    send(8'h03, 7, 0, 0, 0, 3'b000);
    idle(1);
    send(8'h03, 7, 0, 0, 0, 3'b000);
    send(8'h02, 7, 0, 0, 0, 3'b000);
    send(8'h02, 7, 0, 0, 0, 3'b000);
    send(8'h03, 14, 7, 0, 0, 3'b100);
    idle(10);
    chk("youngest_fwd_a", last_fa, 4'b0010);
    send(8'h07, 3, 0, 0, 0, 3'b000);
    send(8'h07, 15, 0, 0, 3, 3'b001);
    idle(2);
    pulse_reset();
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    send(8'h07, 16, 0, 0, 3, 3'b001);
    j = cyc;
    idle(3);
    chk("mid_rst_issue_cycle", last_iss_cyc, j);
    chk("mid_rst_no_stall", stall_cnt, 0);
    pulse_reset();
    j = cyc;
    n0 = n_issue;
    for (int i = 0; i < 20; i++)
      send({5'($urandom), 2'($urandom), 1'b1}, 20 + i, 60 + i, 61 + i, 62 + i, 3'b111);
    chk("stream_cycles", cyc - j, 20);
    idle(2);
    chk("stream_issues", n_issue - n0, 20);
    chk("stream_stall_cnt", stall_cnt, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      c = 8'($urandom);
      c[0] = ($urandom_range(0, 7) != 0);
      send(c, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
           $urandom_range(0, 5), 3'($urandom));
    end
    idle(10);
    pulse_reset();
    send(8'h07, 3, 0, 0, 0, 3'b000);
    for (int i = 0; i < 13110; i++) send(8'h07, 3, 3, 0, 0, 3'b100);
    idle(10);
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
